// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// for the shared-memory datapath, counts retired instructions and flags bad opcodes.
module mips_multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32,
    parameter bit MEM_HS   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPCODE_W-1:0] funct,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                Bneq,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDest,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic                Jal,
    output logic                Lui,
    output logic                Imm,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_JR     = 4'd11;
    localparam logic [3:0] S_IMMEX  = 4'd12;
    localparam logic [3:0] S_IMMWB  = 4'd13;
    localparam logic [3:0] S_ILL    = 4'd14;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);
    localparam logic [OPCODE_W-1:0] FN_JR    = OPCODE_W'(6'b001000);

    logic [3:0]          state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                mem_done;
    logic                retire;

    // With the handshake disabled every memory access completes in its first cycle.
    assign mem_done = MEM_HS ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        op_d    = (state_q == S_DECODE) ? opcode : op_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = (funct == FN_JR) ? S_JR : S_RTEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    OP_ORI, OP_LUI: state_d = S_IMMEX;
                    default:       state_d = S_ILL;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_done ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = mem_done ? S_FETCH : S_MEMWR;
                retire  = mem_done;
            end
            S_RTEX:   state_d = S_RTWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_IMMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    // Everything is held at zero while reset is high so an aborted instruction
    // cannot leak a write enable in the cycle reset is first seen.
    always_comb begin
        PCWrite = 1'b0; PCWriteCond = 1'b0; Bneq = 1'b0; IorD = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0;
        RegDest = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; Jal = 1'b0;
        Lui = 1'b0; Imm = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00;
        PCSource = 2'b00; illegal = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_done;
                    PCWrite = mem_done;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_RTEX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RTWB: begin
                    RegWrite = 1'b1;
                    RegDest  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    Bneq        = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    RegWrite = 1'b1;
                    Jal      = 1'b1;
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                S_IMMEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                    Imm     = 1'b1;
                    Lui     = (op_q == OP_LUI);
                end
                S_IMMWB: begin
                    RegWrite = 1'b1;
                    Imm      = 1'b1;
                    Lui      = (op_q == OP_LUI);
                end
                S_ILL:   illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = reset ? S_FETCH : state_q;
    assign retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: one instance without the memory
// handshake (4-bit retire counter) and one with it (32-bit counter).
module tb_mips_multicycle_control;

    // Control vector packing:
    // {PCWrite,PCWriteCond,Bneq,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    //  RegDest,RegWrite,ALUSrcA,Jal,Lui,Imm,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    localparam logic [19:0] V_ZERO   = 20'b0000_0000_0000_0000_0000;
    localparam logic [19:0] V_FETCH  = 20'b1000_1010_0000_0001_0000;
    localparam logic [19:0] V_FSTALL = 20'b0000_1000_0000_0001_0000;
    localparam logic [19:0] V_DEC    = 20'b0000_0000_0000_0011_0000;
    localparam logic [19:0] V_MADR   = 20'b0000_0000_0010_0010_0000;
    localparam logic [19:0] V_MRD    = 20'b0001_1000_0000_0000_0000;
    localparam logic [19:0] V_MWB    = 20'b0000_0001_0100_0000_0000;
    localparam logic [19:0] V_MWR    = 20'b0001_0100_0000_0000_0000;
    localparam logic [19:0] V_RTEX   = 20'b0000_0000_0010_0000_1000;
    localparam logic [19:0] V_RTWB   = 20'b0000_0000_1100_0000_0000;
    localparam logic [19:0] V_BNE    = 20'b0110_0000_0010_0000_0101;
    localparam logic [19:0] V_BEQ    = 20'b0100_0000_0010_0000_0101;
    localparam logic [19:0] V_J      = 20'b1000_0000_0000_0000_0010;
    localparam logic [19:0] V_JAL    = 20'b1000_0000_0101_0000_0010;
    localparam logic [19:0] V_JR     = 20'b1000_0000_0000_0000_0011;
    localparam logic [19:0] V_LUIEX  = 20'b0000_0000_0010_1110_1100;
    localparam logic [19:0] V_ORIEX  = 20'b0000_0000_0010_0110_1100;
    localparam logic [19:0] V_LUIWB  = 20'b0000_0000_0100_1100_0000;
    localparam logic [19:0] V_ORIWB  = 20'b0000_0000_0100_0100_0000;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011,
                           ORI = 6'b001101, LUI = 6'b001111, BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst0, rst1, mem_ready;
    logic [5:0] opcode, funct;
    wire  [19:0] c0, c1;
    wire  [3:0]  s0, s1;
    wire         ill0, ill1;
    wire  [3:0]  r0;
    wire  [31:0] r1;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.OPCODE_W(6), .CNT_W(4), .MEM_HS(1'b0)) u0 (
        .clk(clk), .reset(rst0), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(c0[19]), .PCWriteCond(c0[18]), .Bneq(c0[17]), .IorD(c0[16]),
        .MemRead(c0[15]), .MemWrite(c0[14]), .IRWrite(c0[13]), .MemtoReg(c0[12]),
        .RegDest(c0[11]), .RegWrite(c0[10]), .ALUSrcA(c0[9]), .Jal(c0[8]),
        .Lui(c0[7]), .Imm(c0[6]), .ALUSrcB(c0[5:4]), .ALUOp(c0[3:2]),
        .PCSource(c0[1:0]), .state(s0), .illegal(ill0), .retired(r0)
    );

    mips_multicycle_control #(.OPCODE_W(6), .CNT_W(32), .MEM_HS(1'b1)) u1 (
        .clk(clk), .reset(rst1), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(c1[19]), .PCWriteCond(c1[18]), .Bneq(c1[17]), .IorD(c1[16]),
        .MemRead(c1[15]), .MemWrite(c1[14]), .IRWrite(c1[13]), .MemtoReg(c1[12]),
        .RegDest(c1[11]), .RegWrite(c1[10]), .ALUSrcA(c1[9]), .Jal(c1[8]),
        .Lui(c1[7]), .Imm(c1[6]), .ALUSrcB(c1[5:4]), .ALUOp(c1[3:2]),
        .PCSource(c1[1:0]), .state(s1), .illegal(ill1), .retired(r1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [3:0] st, input logic [19:0] cv);
        chk({tag, ".state"}, 32'(s0), 32'(st));
        chk({tag, ".ctl"}, 32'(c0), 32'(cv));
    endtask

    task automatic chk1(input string tag, input logic [3:0] st, input logic [19:0] cv);
        chk({tag, ".state"}, 32'(s1), 32'(st));
        chk({tag, ".ctl"}, 32'(c1), 32'(cv));
    endtask

    // Present an instruction on u0 and walk it through FETCH and DECODE.
    task automatic fd0(input string tag, input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        #1;
        chk0({tag, ".F"}, 4'd0, V_FETCH);
        tick();
        chk0({tag, ".D"}, 4'd1, V_DEC);
        tick();
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0;
        tick(); tick();
        chk0("rst", 4'd0, V_ZERO);
        chk("rst.ill", 32'(ill0), 32'd0);
        chk("rst.ret", 32'(r0), 32'd0);

        // lw without handshake; the opcode port changes after DECODE and must be ignored
        opcode = LW; rst0 = 1'b0; #1;
        chk0("lw.F", 4'd0, V_FETCH);
        tick(); chk0("lw.D", 4'd1, V_DEC);
        tick(); chk0("lw.MA", 4'd2, V_MADR);
        opcode = SW; #1;
        tick(); chk0("lw.MR", 4'd3, V_MRD);
        tick(); chk0("lw.WB", 4'd4, V_MWB);
        tick(); chk0("lw.end", 4'd0, V_FETCH);
        chk("lw.ret", 32'(r0), 32'd1);

        fd0("bne", BNE, 6'd0);   chk0("bne.B", 4'd8, V_BNE);  tick(); chk("bne.ret", 32'(r0), 32'd2);
        fd0("beq", BEQ, 6'd0);   chk0("beq.B", 4'd8, V_BEQ);  tick(); chk("beq.ret", 32'(r0), 32'd3);
        fd0("jr", 6'd0, 6'b001000); chk0("jr.X", 4'd11, V_JR); tick(); chk("jr.ret", 32'(r0), 32'd4);

        fd0("lui", LUI, 6'd0);   chk0("lui.EX", 4'd12, V_LUIEX);
        opcode = ORI; #1;
        tick(); chk0("lui.WB", 4'd13, V_LUIWB);
        tick(); chk("lui.ret", 32'(r0), 32'd5);

        fd0("ori", ORI, 6'd0);   chk0("ori.EX", 4'd12, V_ORIEX);
        tick(); chk0("ori.WB", 4'd13, V_ORIWB);
        tick(); chk("ori.ret", 32'(r0), 32'd6);

        fd0("rt", 6'd0, 6'b100000); chk0("rt.EX", 4'd6, V_RTEX);
        tick(); chk0("rt.WB", 4'd7, V_RTWB);
        tick(); chk("rt.ret", 32'(r0), 32'd7);

        fd0("j", J, 6'd0);       chk0("j.X", 4'd9, V_J);      tick(); chk("j.ret", 32'(r0), 32'd8);
        fd0("jal", JAL, 6'd0);   chk0("jal.X", 4'd10, V_JAL); tick(); chk("jal.ret", 32'(r0), 32'd9);

        // sw without handshake completes in one MEMWR cycle even with mem_ready low
        fd0("sw", SW, 6'd0);     chk0("sw.MA", 4'd2, V_MADR);
        tick(); chk0("sw.MW", 4'd5, V_MWR);
        tick(); chk0("sw.end", 4'd0, V_FETCH);
        chk("sw.ret", 32'(r0), 32'd10);

        fd0("ill", BAD, 6'd0);   chk0("ill.X", 4'd14, V_ZERO);
        chk("ill.pulse", 32'(ill0), 32'd1);
        tick(); chk0("ill.end", 4'd0, V_FETCH);
        chk("ill.clr", 32'(ill0), 32'd0);
        chk("ill.ret", 32'(r0), 32'd10);

        // six more jumps take the 4-bit counter from 10 through 15 to 0
        for (int i = 0; i < 6; i++) begin
            fd0("jw", J, 6'd0);
            tick();
        end
        chk("wrap.ret", 32'(r0), 32'd0);
        rst0 = 1'b1;

        // handshake instance: FETCH and MEMRD stall on mem_ready
        rst1 = 1'b0; opcode = LW; funct = '0; mem_ready = 1'b0; #1;
        chk1("hs.F0", 4'd0, V_FSTALL);
        tick(); chk1("hs.F1", 4'd0, V_FSTALL);
        mem_ready = 1'b1; #1;
        chk1("hs.F2", 4'd0, V_FETCH);
        tick(); chk1("hs.D", 4'd1, V_DEC);
        tick(); chk1("hs.MA", 4'd2, V_MADR);
        mem_ready = 1'b0; #1;
        tick(); chk1("hs.MR0", 4'd3, V_MRD);
        tick(); chk1("hs.MR1", 4'd3, V_MRD);
        tick(); chk1("hs.MR2", 4'd3, V_MRD);
        mem_ready = 1'b1; #1;
        tick(); chk1("hs.WB", 4'd4, V_MWB);
        tick(); chk1("hs.end", 4'd0, V_FETCH);
        chk("hs.ret", r1, 32'd1);

        // sw stalls in MEMWR with MemWrite held, then reset aborts it
        opcode = SW; #1;
        tick(); chk1("hsw.D", 4'd1, V_DEC);
        tick(); chk1("hsw.MA", 4'd2, V_MADR);
        mem_ready = 1'b0; #1;
        tick(); chk1("hsw.MW0", 4'd5, V_MWR);
        tick(); chk1("hsw.MW1", 4'd5, V_MWR);
        rst1 = 1'b1; #1;
        chk("abort.ctl", 32'(c1), 32'd0);
        tick(); chk1("abort.rst", 4'd0, V_ZERO);
        chk("abort.ret", r1, 32'd0);
        rst1 = 1'b0; #1;
        chk1("abort.F", 4'd0, V_FSTALL);
        chk("abort.ret2", r1, 32'd0);
        chk("abort.ill", 32'(ill1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
